str_store_buffer: RTL and testbench

- Store-side counterpart of the LDR writeback path: it accepts STR requests carrying an address from the ALU and data from the register bank, and drains them into RAM.
- Requests are queued in a small FIFO so the datapath only stalls when the FIFO is full.
- A drain FSM presents one write at a time to RAM with a ready/ack handshake and a timeout.
- The block sits between memory control / register bank and the RAM write port.

---
 rtl/str_store_buffer.sv | 161 ++++++++++++++++
 tb/tb_str_store_buffer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/str_store_buffer.sv
// Purpose: queues STR stores {addr,data} and drains them one at a time into the RAM write port.
// Latency: str_req sampled at edge N into an empty buffer -> ram_wr_en high after edge N+1.
// Backpressure: str_full while DEPTH entries are pending; a store offered while full is dropped and flagged.
//
// Ports:
//   clk, reset_n                  - clock, synchronous active-low reset
//   str_req/str_addr/str_data     - store request from memory control / ALU / register bank
//   str_full, buf_empty           - buffer full; buffer empty with the drain FSM idle
//   ram_wr_en/ram_addr/ram_wr_data, ram_ack - registered RAM write port and its accept strobe
//   err_overflow, err_timeout     - sticky error flags, cleared only by reset
//   ldr_addr, fwd_hit, fwd_data   - store-to-load forwarding lookup
//
// Build option: define STORE_FWD_EN to enable forwarding; otherwise fwd_hit/fwd_data read 0.
module str_store_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  str_req,
  input  logic [ADDR_WIDTH-1:0] str_addr,
  input  logic [DATA_WIDTH-1:0] str_data,
  output logic                  str_full,
  output logic                  buf_empty,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  input  logic                  ram_ack,
  output logic                  err_overflow,
  output logic                  err_timeout,
  input  logic [ADDR_WIDTH-1:0] ldr_addr,
  output logic                  fwd_hit,
  output logic [DATA_WIDTH-1:0] fwd_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] head_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic [7:0]       tmo_cnt;
  state_t           state;

  logic push;
  logic pop;
  logic tmo_hit;

  assign str_full  = (count == CNT_W'(DEPTH));
  assign buf_empty = (count == '0) && (state == IDLE);

  // A push is refused on a full buffer even if the head pops on the same edge.
  assign push     = str_req && !str_full;
  assign tmo_hit  = (tmo_cnt == 8'(TIMEOUT - 1));
  // The head leaves the buffer on ack, or is dropped when the wait budget runs out.
  assign pop      = (state == WRITE) && (ram_ack || tmo_hit);
  assign head_nxt = head + PTR_W'(1);

  always_comb begin
    count_nxt = count + CNT_W'(push) - CNT_W'(pop);
  end

  // Storage needs no reset: validity is tracked by head/count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail] <= str_addr;
      data_mem[tail] <= str_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      tmo_cnt      <= '0;
      ram_wr_en    <= 1'b0;
      ram_addr     <= '0;
      ram_wr_data  <= '0;
      err_overflow <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      count <= count_nxt;
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head_nxt;
      if (str_req && str_full) err_overflow <= 1'b1;

      case (state)
        IDLE: begin
          if (count != '0) begin
            state       <= WRITE;
            ram_wr_en   <= 1'b1;
            ram_addr    <= addr_mem[head];
            ram_wr_data <= data_mem[head];
            tmo_cnt     <= '0;
          end
        end
        WRITE: begin
          if (pop) begin
            if (!ram_ack) err_timeout <= 1'b1;
            tmo_cnt <= '0;
            if (count_nxt != '0) begin
              // Back-to-back: the next head is either already stored, or it is
              // the entry being pushed on this very edge (buffer held only the popped one).
              if (count > CNT_W'(1)) begin
                ram_addr    <= addr_mem[head_nxt];
                ram_wr_data <= data_mem[head_nxt];
              end else begin
                ram_addr    <= str_addr;
                ram_wr_data <= str_data;
              end
            end else begin
              state     <= IDLE;
              ram_wr_en <= 1'b0;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
      endcase
    end
  end

`ifdef STORE_FWD_EN
  logic [PTR_W-1:0] fwd_idx;

  // Scan oldest to youngest so the last match (youngest store) wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (addr_mem[fwd_idx] == ldr_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[fwd_idx];
      end
    end
  end
`else
  logic unused_ldr_addr;

  assign unused_ldr_addr = ^ldr_addr;
  assign fwd_hit         = 1'b0;
  assign fwd_data        = '0;
`endif

endmodule

// File: tb/tb_str_store_buffer.sv
module tb_str_store_buffer;

  localparam int DW      = 32;
  localparam int AW      = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          str_req;
  logic [AW-1:0] str_addr;
  logic [DW-1:0] str_data;
  logic          str_full;
  logic          buf_empty;
  logic          ram_wr_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wr_data;
  logic          ram_ack;
  logic          err_overflow;
  logic          err_timeout;
  logic [AW-1:0] ldr_addr;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;

  always #5 clk = ~clk;

  str_store_buffer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .str_req(str_req), .str_addr(str_addr), .str_data(str_data),
    .str_full(str_full), .buf_empty(buf_empty),
    .ram_wr_en(ram_wr_en), .ram_addr(ram_addr), .ram_wr_data(ram_wr_data),
    .ram_ack(ram_ack),
    .err_overflow(err_overflow), .err_timeout(err_timeout),
    .ldr_addr(ldr_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply inputs, let one rising edge pass, sample 1 time unit later.
  task automatic cyc(input logic rn, input logic rq, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic ak);
    reset_n  = rn;
    str_req  = rq;
    str_addr = a;
    str_data = d;
    ram_ack  = ak;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          rn, rq;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          ak;
    logic          wen;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          full, empty, ovf, tmo;
  } vec_t;

  vec_t vecs[12];

  // Reference model: a queue of pending stores, head = entry on the RAM port.
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t q[$];
  bit   m_wr;
  int   m_wait;
  bit   m_ovf;
  bit   m_tmo;

  task automatic model_step(input logic rn, input logic rq, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic ak);
    bit full;
    bit pop;
    int old;
    if (!rn) begin
      q.delete();
      m_wr = 0; m_wait = 0; m_ovf = 0; m_tmo = 0;
    end else begin
      full = (q.size() == DEPTH);
      old  = q.size();
      pop  = 0;
      if (rq && full) m_ovf = 1;
      if (m_wr && (ak || m_wait == TIMEOUT - 1)) begin
        pop = 1;
        if (!ak) m_tmo = 1;
      end
      if (pop) void'(q.pop_front());
      if (rq && !full) q.push_back(ent_t'({a, d}));
      if (m_wr) begin
        if (pop) begin
          m_wr   = (q.size() != 0);
          m_wait = 0;
        end else begin
          m_wait++;
        end
      end else if (old != 0) begin
        m_wr   = 1;
        m_wait = 0;
      end
    end
  endtask

  task automatic model_compare(input int cycle);
    bit            e_hit;
    logic [DW-1:0] e_fd;
    e_hit = 0;
    e_fd  = '0;
`ifdef STORE_FWD_EN
    foreach (q[i]) begin
      if (q[i].a == ldr_addr) begin
        e_hit = 1;
        e_fd  = q[i].d;
      end
    end
`endif
    check($sformatf("rnd%0d.wen", cycle), ram_wr_en, m_wr);
    if (m_wr) begin
      check($sformatf("rnd%0d.addr", cycle), ram_addr, q[0].a);
      check($sformatf("rnd%0d.data", cycle), ram_wr_data, q[0].d);
    end
    check($sformatf("rnd%0d.full", cycle), str_full, q.size() == DEPTH);
    check($sformatf("rnd%0d.empty", cycle), buf_empty, (q.size() == 0) && !m_wr);
    check($sformatf("rnd%0d.ovf", cycle), err_overflow, m_ovf);
    check($sformatf("rnd%0d.tmo", cycle), err_timeout, m_tmo);
    check($sformatf("rnd%0d.fwd_hit", cycle), fwd_hit, e_hit);
    check($sformatf("rnd%0d.fwd_data", cycle), fwd_data, e_fd);
  endtask

  initial begin
    logic          exp_hit;
    logic [DW-1:0] exp_fd;

    reset_n = 1'b0; str_req = 1'b0; str_addr = '0; str_data = '0;
    ram_ack = 1'b0; ldr_addr = '0;

    // ---------------- reset state ----------------
    cyc(1'b0, 1'b0, 8'h0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 8'h0, 32'h0, 1'b0);
    check("rst.wen",   ram_wr_en, 1'b0);
    check("rst.addr",  ram_addr, 8'h0);
    check("rst.data",  ram_wr_data, 32'h0);
    check("rst.full",  str_full, 1'b0);
    check("rst.empty", buf_empty, 1'b1);
    check("rst.ovf",   err_overflow, 1'b0);
    check("rst.tmo",   err_timeout, 1'b0);
    check("rst.fwd",   fwd_hit, 1'b0);

    // ---------------- table: single store, then burst with backpressure ----------------
    //           rn    rq    addr   data           ak    wen   eaddr  edata          full  empty ovf   tmo
    vecs[0]  = '{1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 1'b1, 1'b0, 8'h00, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 8'h00, 32'h0,        1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 8'h00, 32'h0,        1'b1, 1'b0, 8'h00, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 8'h01, 32'h101,      1'b0, 1'b0, 8'h00, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 8'h02, 32'h102,      1'b0, 1'b1, 8'h01, 32'h101,      1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 8'h03, 32'h103,      1'b0, 1'b1, 8'h01, 32'h101,      1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 8'h04, 32'h104,      1'b0, 1'b1, 8'h01, 32'h101,      1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 8'h05, 32'h105,      1'b0, 1'b1, 8'h01, 32'h101,      1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 8'h00, 32'h0,        1'b1, 1'b1, 8'h02, 32'h102,      1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 8'h00, 32'h0,        1'b1, 1'b1, 8'h03, 32'h103,      1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 8'h00, 32'h0,        1'b1, 1'b1, 8'h04, 32'h104,      1'b0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 8'h00, 32'h0,        1'b1, 1'b0, 8'h00, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0};

    for (int i = 0; i < 12; i++) begin
      cyc(vecs[i].rn, vecs[i].rq, vecs[i].a, vecs[i].d, vecs[i].ak);
      check($sformatf("v%0d.wen", i), ram_wr_en, vecs[i].wen);
      if (vecs[i].wen) begin
        check($sformatf("v%0d.addr", i), ram_addr, vecs[i].ea);
        check($sformatf("v%0d.data", i), ram_wr_data, vecs[i].ed);
      end
      check($sformatf("v%0d.full", i), str_full, vecs[i].full);
      check($sformatf("v%0d.empty", i), buf_empty, vecs[i].empty);
      check($sformatf("v%0d.ovf", i), err_overflow, vecs[i].ovf);
      check($sformatf("v%0d.tmo", i), err_timeout, vecs[i].tmo);
    end

    // ---------------- timeout: write held for TIMEOUT cycles, then dropped ----------------
    cyc(1'b0, 1'b0, 8'h0, 32'h0, 1'b0);
    cyc(1'b1, 1'b1, 8'h33, 32'h3333, 1'b0);
    for (int k = 0; k < TIMEOUT; k++) begin
      cyc(1'b1, 1'b0, 8'h0, 32'h0, 1'b0);
      check($sformatf("tmo.wen%0d", k), ram_wr_en, 1'b1);
      check($sformatf("tmo.flag%0d", k), err_timeout, 1'b0);
    end
    check("tmo.addr", ram_addr, 8'h33);
    cyc(1'b1, 1'b0, 8'h0, 32'h0, 1'b0);
    check("tmo.wen_end",   ram_wr_en, 1'b0);
    check("tmo.flag_end",  err_timeout, 1'b1);
    check("tmo.empty_end", buf_empty, 1'b1);

    // ---------------- reset mid-burst (err_timeout is still set here) ----------------
    cyc(1'b1, 1'b1, 8'h51, 32'h51, 1'b0);
    cyc(1'b1, 1'b1, 8'h52, 32'h52, 1'b0);
    cyc(1'b1, 1'b1, 8'h53, 32'h53, 1'b0);
    check("mid.wen_before", ram_wr_en, 1'b1);
    cyc(1'b0, 1'b1, 8'h54, 32'h54, 1'b0);
    check("mid.wen",   ram_wr_en, 1'b0);
    check("mid.empty", buf_empty, 1'b1);
    check("mid.full",  str_full, 1'b0);
    check("mid.tmo",   err_timeout, 1'b0);
    check("mid.ovf",   err_overflow, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 1'b0, 8'h0, 32'h0, 1'b1);
      check($sformatf("mid.quiet%0d", k), ram_wr_en, 1'b0);
    end

    // ---------------- simultaneous push/pop with two pending ----------------
    cyc(1'b1, 1'b1, 8'h41, 32'hA41, 1'b0);
    cyc(1'b1, 1'b1, 8'h42, 32'hA42, 1'b0);
    check("pp.addrA", ram_addr, 8'h41);
    cyc(1'b1, 1'b1, 8'h43, 32'hA43, 1'b1);
    check("pp.wenB",  ram_wr_en, 1'b1);
    check("pp.addrB", ram_addr, 8'h42);
    check("pp.dataB", ram_wr_data, 32'hA42);
    cyc(1'b1, 1'b0, 8'h0, 32'h0, 1'b1);
    check("pp.addrC", ram_addr, 8'h43);
    check("pp.dataC", ram_wr_data, 32'hA43);
    cyc(1'b1, 1'b0, 8'h0, 32'h0, 1'b1);
    check("pp.wen_end",   ram_wr_en, 1'b0);
    check("pp.empty_end", buf_empty, 1'b1);

    // ---------------- single pending popped while a new store arrives ----------------
    cyc(1'b1, 1'b1, 8'h61, 32'hB61, 1'b0);
    cyc(1'b1, 1'b0, 8'h0, 32'h0, 1'b0);
    check("byp.addrD", ram_addr, 8'h61);
    cyc(1'b1, 1'b1, 8'h62, 32'hB62, 1'b1);
    check("byp.wenE",  ram_wr_en, 1'b1);
    check("byp.addrE", ram_addr, 8'h62);
    check("byp.dataE", ram_wr_data, 32'hB62);
    cyc(1'b1, 1'b0, 8'h0, 32'h0, 1'b1);
    check("byp.empty", buf_empty, 1'b1);

    // ---------------- forwarding ----------------
    ldr_addr = 8'h20;
    cyc(1'b1, 1'b1, 8'h20, 32'h1, 1'b0);
    cyc(1'b1, 1'b1, 8'h20, 32'h2, 1'b0);
`ifdef STORE_FWD_EN
    exp_hit = 1'b1; exp_fd = 32'h2;
`else
    exp_hit = 1'b0; exp_fd = 32'h0;
`endif
    check("fwd.hit",  fwd_hit, exp_hit);
    check("fwd.data", fwd_data, exp_fd);
    ldr_addr = 8'h21;
    #1;
    check("fwd.miss", fwd_hit, 1'b0);

    // ---------------- randomized run against the queue model ----------------
    cyc(1'b0, 1'b0, 8'h0, 32'h0, 1'b0);
    model_step(1'b0, 1'b0, 8'h0, 32'h0, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      logic          rn, rq, ak;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int            ack_pct;
      ack_pct  = ((c / 500) % 2 == 1) ? 3 : 50;
      rn       = ($urandom_range(0, 299) != 0);
      rq       = 1'($urandom_range(0, 1));
      a        = AW'($urandom_range(0, 7));
      d        = $urandom;
      ak       = ($urandom_range(0, 99) < ack_pct);
      ldr_addr = AW'($urandom_range(0, 7));
      model_step(rn, rq, a, d, ak);
      cyc(rn, rq, a, d, ak);
      model_compare(c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
